lsu_ctrl: RTL and testbench
===========================

LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL use one clock, clk_i, and one synchronous active-high reset, rst_i.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255, giving the maximum cycles spent in ISSUE before abort (used only when LSU_TIMEOUT_EN is defined).
REQ-003 The block SHALL have the ports below, clock and reset first (name  direction  width  meaning):
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- req_valid_i  in  1  pipeline request valid
- req_ready_o  out  1  block can accept a request
- req_we_i  in  1  1 = store, 0 = load
- req_size_onehot_i  in  5  size encoding: [0] LB, [1] LBU, [2] LH, [3] LHU, [4] LW; stores use [0] SB, [2] SH, [4] SW
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, right-aligned
- flush_i  in  1  pipeline flush
- resp_valid_o  out  1  one-cycle completion pulse
- resp_rdata_o  out  32  formatted load data
- resp_misaligned_o  out  1  misaligned-access exception
- resp_err_o  out  1  bus error or timeout
- mem_valid_o  out  1  bus request valid
- mem_ready_i  in  1  bus request accepted
- mem_addr_o  out  32  word address: req_addr_i[31:2], 2'b00
- mem_we_o  out  1  bus write
- mem_wstrb_o  out  4  byte enables, for loads and stores
- mem_wdata_o  out  32  lane-replicated store data
- mem_rvalid_i  in  1  bus response valid (read data or write acknowledge)
- mem_rdata_i  in  32  raw bus read word
- mem_err_i  in  1  bus error, qualified by mem_rvalid_i
- busy_o  out  1  state is not IDLE

Function
REQ-004 The block SHALL implement the states IDLE, ISSUE, WAIT, DONE and DRAIN.
REQ-005 req_ready_o SHALL be 1 only in IDLE with rst_i low; a request is accepted when req_valid_i and req_ready_o are both 1.
REQ-006 On accept, the block SHALL check alignment: a halfword is misaligned when addr[0]=1; a word is misaligned when addr[1:0]!=0; a byte is never misaligned.
REQ-007 On a misaligned accept, the block SHALL go to DONE with resp_misaligned_o=1, and mem_valid_o SHALL never assert for that request.
REQ-008 On an aligned accept, the block SHALL register the address, size, we and wdata, and go to ISSUE.
REQ-009 In ISSUE, mem_valid_o=1 and mem_addr_o, mem_we_o, mem_wstrb_o and mem_wdata_o SHALL stay stable until mem_ready_i=1; then the block goes to WAIT.
REQ-010 Strobes SHALL be: byte 4'h1<<addr[1:0]; half 4'h3<<(2*addr[1]); word 4'hF.
REQ-011 mem_wdata_o SHALL be {4{wdata[7:0]}} for a byte, {2{wdata[15:0]}} for a half, and wdata for a word.
REQ-012 In WAIT, on mem_rvalid_i the block SHALL capture resp_rdata_o and resp_err_o=mem_err_i, then go to DONE.
REQ-013 For a store, resp_rdata_o SHALL be 0.
REQ-014 For a load, resp_rdata_o SHALL be mem_rdata_i>>(8*addr[1:0]), sign-extended (LB, LH) or zero-extended (LBU, LHU) from the access width.
REQ-015 mem_rvalid_i SHALL be ignored outside WAIT; the bus returns it no earlier than the cycle after the mem_ready_i handshake.
REQ-016 DONE SHALL assert resp_valid_o for exactly one cycle, then go to IDLE; resp_* outputs hold their value until the next DONE.
REQ-017 Minimum aligned latency SHALL be: accept at T, handshake at T+1, rvalid at T+2, resp_valid_o at T+3.
REQ-018 flush_i in ISSUE before the handshake SHALL return the block to IDLE with no bus transfer and no response.
REQ-019 flush_i in ISSUE on the handshake cycle, or in WAIT, SHALL send the block to DRAIN; DRAIN waits for mem_rvalid_i, then goes to IDLE without resp_valid_o.
REQ-020 flush_i in IDLE SHALL block acceptance that cycle.
REQ-021 flush_i in DONE SHALL suppress resp_valid_o and send the block to IDLE.
REQ-022 A request with an all-zero req_size_onehot_i SHALL complete through DONE with resp_err_o=1 and no bus access.

Reset
REQ-023 While rst_i=1 the block SHALL enter IDLE with all outputs 0 (including req_ready_o, mem_valid_o and resp_*) and the timeout counter cleared.
REQ-024 Reset mid-transaction SHALL abandon the transaction with no response; the bus is reset together with the block.

Configuration
REQ-025 With LSU_TIMEOUT_EN defined, an 8+ bit counter SHALL count cycles in ISSUE.
REQ-026 With LSU_TIMEOUT_EN defined, after TIMEOUT_CYCLES cycles without mem_ready_i, mem_valid_o SHALL drop and the block SHALL go to DONE with resp_err_o=1.
REQ-027 With LSU_TIMEOUT_EN undefined, there SHALL be no counter and ISSUE SHALL wait indefinitely.

Verification
REQ-028 LB at 0x1003, mem_rdata_i=0x80FF_FF00 -> wstrb 4'h8, mem_addr_o 0x1000, resp_rdata_o 0xFFFF_FF80.
REQ-029 SH at 0x2002, wdata 0x0000_BEEF -> mem_wdata_o 0xBEEF_BEEF, wstrb 4'hC, resp_valid_o one cycle after rvalid.
REQ-030 LW at 0x3001 -> resp_misaligned_o=1 one cycle after accept, mem_valid_o never 1.
REQ-031 LHU at 0x4002, mem_ready_i held low 3 cycles -> address/strobe stable throughout, resp 0x0000_xxxx from upper half, zero-extended.
REQ-032 flush_i in WAIT, then rvalid -> no resp_valid_o, req_ready_o=1 the cycle after the rvalid.
REQ-033 With LSU_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_ready_i stuck at 0 -> mem_valid_o drops after 4 cycles, then resp_err_o=1 with resp_valid_o.

Source files
------------

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - single-outstanding load/store controller between pipeline and memory bus
// Optional feature: define LSU_TIMEOUT_EN to abort ISSUE after TIMEOUT_CYCLES cycles.
module lsu_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [4:0]  req_size_onehot_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_wdata_i,
  input  logic        flush_i,
  output logic        resp_valid_o,
  output logic [31:0] resp_rdata_o,
  output logic        resp_misaligned_o,
  output logic        resp_err_o,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_rvalid_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_err_i,
  output logic        busy_o
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [4:0]  size_q, size_d;
  logic        we_q, we_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;

  logic        live, accept, req_mis, q_word, q_half, timeout;
  logic [31:0] shifted, load_data;

  assign live   = !rst_i;
  assign accept = req_valid_i && req_ready_o;

  always_comb begin
    req_mis = 1'b0;
    if (req_size_onehot_i[4])                             req_mis = (req_addr_i[1:0] != 2'b00);
    else if (req_size_onehot_i[2] || req_size_onehot_i[3]) req_mis = req_addr_i[0];
  end

  assign q_word = size_q[4];
  assign q_half = !size_q[4] && (size_q[2] || size_q[3]);

`ifdef LSU_TIMEOUT_EN
  localparam int unsigned CW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter is zero outside ISSUE, so it restarts on every entry.
  assign cnt_d   = (state_q == S_ISSUE) ? cnt_q + 1'b1 : '0;
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    shifted   = mem_rdata_i >> {addr_q[1:0], 3'b000};
    load_data = '0;
    if (we_q)           load_data = '0;
    else if (size_q[4]) load_data = mem_rdata_i;
    else if (size_q[2]) load_data = {{16{shifted[15]}}, shifted[15:0]};
    else if (size_q[3]) load_data = {16'h0000, shifted[15:0]};
    else if (size_q[0]) load_data = {{24{shifted[7]}}, shifted[7:0]};
    else if (size_q[1]) load_data = {24'h000000, shifted[7:0]};
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (accept) begin
        addr_d  = req_addr_i;
        size_d  = req_size_onehot_i;
        we_d    = req_we_i;
        wdata_d = req_wdata_i;
        if (req_size_onehot_i == 5'b00000) begin
          state_d = S_DONE; rdata_d = '0; mis_d = 1'b0; err_d = 1'b1;
        end else if (req_mis) begin
          state_d = S_DONE; rdata_d = '0; mis_d = 1'b1; err_d = 1'b0;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (flush_i)          state_d = mem_ready_i ? S_DRAIN : S_IDLE;
        else if (mem_ready_i) state_d = S_WAIT;
        else if (timeout) begin
          state_d = S_DONE; rdata_d = '0; mis_d = 1'b0; err_d = 1'b1;
        end
      end
      S_WAIT: begin
        // A flush coinciding with the response consumes it silently.
        if (mem_rvalid_i) begin
          if (flush_i) state_d = S_IDLE;
          else begin
            state_d = S_DONE; rdata_d = load_data; mis_d = 1'b0; err_d = mem_err_i;
          end
        end else if (flush_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_DRAIN: if (mem_rvalid_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
    end
  end

  assign req_ready_o       = live && (state_q == S_IDLE) && !flush_i;
  assign mem_valid_o       = live && (state_q == S_ISSUE);
  assign resp_valid_o      = live && (state_q == S_DONE) && !flush_i;
  assign busy_o            = live && (state_q != S_IDLE);
  assign resp_rdata_o      = live ? rdata_q : '0;
  assign resp_misaligned_o = live && mis_q;
  assign resp_err_o        = live && err_q;
  assign mem_addr_o        = live ? {addr_q[31:2], 2'b00} : '0;
  assign mem_we_o          = live && we_q;

  always_comb begin
    mem_wstrb_o = 4'h0;
    mem_wdata_o = '0;
    if (live) begin
      if (q_word) begin
        mem_wstrb_o = 4'hF;
        mem_wdata_o = wdata_q;
      end else if (q_half) begin
        mem_wstrb_o = 4'h3 << {addr_q[1], 1'b0};
        mem_wdata_o = {2{wdata_q[15:0]}};
      end else begin
        mem_wstrb_o = 4'h1 << addr_q[1:0];
        mem_wdata_o = {4{wdata_q[7:0]}};
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [4:0]  req_size = 5'b0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        flush = 1'b0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_mis;
    logic        resp_err;
    logic        mem_valid;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_err = 1'b0;
    logic        busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_size_onehot_i(req_size), .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .flush_i(flush),
        .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata),
        .resp_misaligned_o(resp_mis), .resp_err_o(resp_err),
        .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
        .mem_we_o(mem_we), .mem_wstrb_o(mem_wstrb), .mem_wdata_o(mem_wdata),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata), .mem_err_i(mem_err),
        .busy_o(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic we, input logic [4:0] sz, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = wd;
        #1;
        check("accept_ready", req_ready, 1'b1);
        tick();
        req_valid = 1'b0; req_we = 1'b0; req_size = 5'b0; req_addr = 32'h0; req_wdata = 32'h0;
    endtask

    initial begin
        req_valid = 1'b1; req_size = 5'b10000;
        tick(); tick();
        check("rst_ready", req_ready, 1'b0);
        check("rst_mem_valid", mem_valid, 1'b0);
        check("rst_resp_valid", resp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_rdata", resp_rdata, 32'h0);
        req_valid = 1'b0; req_size = 5'b0; rst = 1'b0;
        tick();
        check("idle_ready", req_ready, 1'b1);

        send(1'b0, 5'b00001, 32'h0000_1003, 32'h0);
        mem_ready = 1'b1; #1;
        check("lb_mem_valid", mem_valid, 1'b1);
        check("lb_addr", mem_addr, 32'h0000_1000);
        check("lb_wstrb", mem_wstrb, 4'h8);
        check("lb_we", mem_we, 1'b0);
        check("lb_busy", busy, 1'b1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_FF00; #1;
        check("lb_wait_nomem", mem_valid, 1'b0);
        check("lb_wait_noresp", resp_valid, 1'b0);
        tick();
        mem_rvalid = 1'b0; mem_rdata = 32'h0; #1;
        check("lb_resp_valid", resp_valid, 1'b1);
        check("lb_rdata", resp_rdata, 32'hFFFF_FF80);
        check("lb_err", resp_err, 1'b0);
        tick();
        check("lb_pulse_end", resp_valid, 1'b0);
        check("lb_rdata_hold", resp_rdata, 32'hFFFF_FF80);
        check("lb_back_ready", req_ready, 1'b1);

        send(1'b1, 5'b00100, 32'h0000_2002, 32'h0000_BEEF);
        mem_ready = 1'b1; #1;
        check("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
        check("sh_wstrb", mem_wstrb, 4'hC);
        check("sh_we", mem_we, 1'b1);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678; #1;
        tick();
        mem_rvalid = 1'b0; #1;
        check("sh_resp_valid", resp_valid, 1'b1);
        check("sh_rdata_zero", resp_rdata, 32'h0);
        tick();

        send(1'b1, 5'b00001, 32'h0000_C001, 32'h1234_56A5);
        #1;
        check("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_wstrb", mem_wstrb, 4'h2);
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; tick();
        mem_rvalid = 1'b0; tick();

        send(1'b0, 5'b10000, 32'h0000_3001, 32'h0);
        check("lw_mis_resp_valid", resp_valid, 1'b1);
        check("lw_mis_flag", resp_mis, 1'b1);
        check("lw_mis_nomem", mem_valid, 1'b0);
        check("lw_mis_err", resp_err, 1'b0);
        tick();
        check("lw_mis_nomem2", mem_valid, 1'b0);

        send(1'b0, 5'b01000, 32'h0000_4002, 32'h0);
        for (int i = 0; i < 3; i++) begin
            check("lhu_stall_valid", mem_valid, 1'b1);
            check("lhu_stall_addr", mem_addr, 32'h0000_4000);
            check("lhu_stall_wstrb", mem_wstrb, 4'hC);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("lhu_hs_addr", mem_addr, 32'h0000_4000);
        tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hABCD_1234; tick();
        mem_rvalid = 1'b0; #1;
        check("lhu_rdata", resp_rdata, 32'h0000_ABCD);
        check("lhu_resp_valid", resp_valid, 1'b1);
        tick();

        send(1'b0, 5'b00100, 32'h0000_5000, 32'h0);
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_err = 1'b1; mem_rdata = 32'h0000_8001; tick();
        mem_rvalid = 1'b0; mem_err = 1'b0; #1;
        check("lh_rdata", resp_rdata, 32'hFFFF_8001);
        check("lh_err", resp_err, 1'b1);
        tick();

        send(1'b0, 5'b10000, 32'h0000_6000, 32'h0);
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; flush = 1'b1; tick();
        flush = 1'b0; #1;
        check("drain_busy", busy, 1'b1);
        check("drain_not_ready", req_ready, 1'b0);
        tick();
        mem_rvalid = 1'b1; #1;
        check("drain_no_resp", resp_valid, 1'b0);
        tick();
        mem_rvalid = 1'b0; #1;
        check("drain_ready_after", req_ready, 1'b1);
        check("drain_no_resp2", resp_valid, 1'b0);

        send(1'b0, 5'b00001, 32'h0000_7000, 32'h0);
        flush = 1'b1; tick();
        flush = 1'b0; #1;
        check("issue_flush_idle", busy, 1'b0);
        check("issue_flush_noresp", resp_valid, 1'b0);

        send(1'b0, 5'b00000, 32'h0000_8000, 32'h0);
        check("zsize_resp_valid", resp_valid, 1'b1);
        check("zsize_err", resp_err, 1'b1);
        check("zsize_mis", resp_mis, 1'b0);
        check("zsize_nomem", mem_valid, 1'b0);
        tick();

        req_valid = 1'b1; req_size = 5'b10000; flush = 1'b1; #1;
        check("idle_flush_ready", req_ready, 1'b0);
        tick();
        req_valid = 1'b0; flush = 1'b0; #1;
        check("idle_flush_notaken", busy, 1'b0);

        send(1'b0, 5'b10000, 32'h0000_9002, 32'h0);
        flush = 1'b1; #1;
        check("done_flush_noresp", resp_valid, 1'b0);
        tick();
        flush = 1'b0; #1;
        check("done_flush_idle", busy, 1'b0);

        send(1'b0, 5'b10000, 32'h0000_A000, 32'h0);
`ifdef LSU_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            check("to_valid_held", mem_valid, 1'b1);
            tick();
        end
        check("to_valid_drop", mem_valid, 1'b0);
        check("to_resp_valid", resp_valid, 1'b1);
        check("to_err", resp_err, 1'b1);
        tick();
`else
        for (int i = 0; i < 10; i++) begin
            check("nto_valid_held", mem_valid, 1'b1);
            tick();
        end
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D; tick();
        mem_rvalid = 1'b0; #1;
        check("nto_rdata", resp_rdata, 32'hCAFE_F00D);
        check("nto_err", resp_err, 1'b0);
        tick();
`endif

        send(1'b0, 5'b10000, 32'h0000_B000, 32'h0);
        mem_ready = 1'b1; tick();
        mem_ready = 1'b0; rst = 1'b1; #1;
        check("midrst_busy", busy, 1'b0);
        check("midrst_rdata", resp_rdata, 32'h0);
        tick();
        rst = 1'b0; #1;
        check("midrst_ready", req_ready, 1'b1);
        check("midrst_noresp", resp_valid, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
